sd_cmd_tx: RTL
==============

// Module: sd_cmd_tx
// PURPOSE
//   Serialises one SD command frame (48 bits) onto the CMD line, sd_clk domain.
//   Frame: start(0), transmission(1), index[5:0], argument[31:0], CRC7, end(1).
//   CRC7 is generated on the fly. Sits directly upstream of sd_receive.
//   sd_send_finished marks CMD-line release; the controller then asserts receive_en.
// PARAMETERS
//   GAP_CYCLES  8  idle-high clocks (Ncc) driven after the end bit before a new command is accepted; >=1
// PORTS
//   sd_clk            in   1   single clock; all logic on posedge
//   reset_n           in   1   asynchronous, active-low reset
//   send_en           in   1   start request; sampled only in IDLE
//   cmd_index         in   6   command index; captured with send_en
//   argument          in   32  command argument; captured with send_en
//   sd_cmd_out        out  1   serial CMD data, MSB first
//   sd_cmd_oe         out  1   CMD pad output enable (1 = host drives)
//   busy              out  1   high from acceptance until GAP ends
//   sd_send_finished  out  1   one-cycle pulse when the line is released
// BEHAVIOUR
//   All outputs are registered.
//   Reset (async, reset_n=0): state=IDLE, sd_cmd_out=1, sd_cmd_oe=0, busy=0,
//     sd_send_finished=0, CRC=0, counters=0.
//   States:
//     IDLE -> SHIFT on send_en.
//     SHIFT (40 bits) -> CRC (7 bits) -> STOP (1 bit) -> GAP (GAP_CYCLES) -> IDLE.
//   Acceptance edge E0 (send_en=1 in IDLE):
//     - Load shift reg = {1'b0, 1'b1, cmd_index, argument}; clear CRC.
//     - Set sd_cmd_oe=1, busy=1, sd_cmd_out=0 (start bit).
//   Bit timing: frame bit k (k=0..47, bit 0 = start) is valid on sd_cmd_out
//     from edge E0+k to edge E0+k+1.
//   CRC7: poly x^7+x^3+1, register init 0, fed bits 0..39 as they are driven.
//     fb = crc[6]^bit; crc <= {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
//     Bits 40..46 = crc[6:0], MSB first. Bit 47 = 1 (end bit).
//   Edge E0+48: sd_cmd_oe=0, sd_cmd_out=1, sd_send_finished=1 for exactly
//     one cycle; enter GAP.
//   GAP: oe=0, out=1, busy=1 for GAP_CYCLES cycles (including E0+48 cycle);
//     busy=0 from edge E0+48+GAP_CYCLES; state is IDLE.
//   send_en while busy=1: ignored, no queuing. cmd_index/argument changes
//     after E0 have no effect on the frame.
//   Earliest next acceptance: edge E0+48+GAP_CYCLES with send_en=1.
//   Reset mid-frame: line released immediately (oe=0, out=1); no
//     sd_send_finished pulse; partial frame is discarded.
//   Back-to-back sends: CRC is re-cleared at each acceptance; no state carries over.
// TESTING
//   1. CMD0, arg 0 -> 48 bits 0x40_0000_0000_95; oe high exactly 48 cycles;
//      finished pulse at E0+48.
//   2. CMD8, arg 0x0000_01AA -> 0x48_0000_01AA_87 (CRC7 0x43).
//   3. CMD17, arg 0 -> 0x51_0000_0000_55 (CRC7 0x2A).
//   4. send_en held high continuously, GAP_CYCLES=8 -> frames start 56 cycles
//      apart; no extra finished pulses.
//   5. reset_n low at bit 20 of a frame -> oe=0, out=1 asynchronously;
//      busy=0; no finished pulse.
//   6. Change cmd_index/argument at E0+5 -> transmitted frame is unchanged.

Source files
------------

// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter: serialises start/dir/index/argument/CRC7/end
// onto CMD with on-the-fly CRC7, then holds the line idle for Ncc clocks.
module sd_cmd_tx #(
    parameter int GAP_CYCLES = 8
) (
    input  logic        sd_clk,
    input  logic        reset_n,
    input  logic        send_en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        sd_send_finished
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CRC,
        STOP,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [39:0]   sreg_q, sreg_d;
    logic [6:0]    crc_q, crc_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          out_q, out_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;
    logic          accept;

    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        crc_d     = crc_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        out_d     = out_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        fin_d     = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept = send_en;
            end
            SHIFT: begin
                // CRC absorbs the bit currently on the line
                crc_d = crc_step(crc_q, sreg_q[39]);
                if (bit_cnt_q == 6'd39) begin
                    state_d   = CRC;
                    out_d     = crc_d[6];
                    bit_cnt_d = '0;
                end else begin
                    sreg_d    = {sreg_q[38:0], 1'b0};
                    out_d     = sreg_q[38];
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            CRC: begin
                if (bit_cnt_q == 6'd6) begin
                    state_d   = STOP;
                    out_d     = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    crc_d     = {crc_q[5:0], 1'b0};
                    out_d     = crc_q[5];
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            STOP: begin
                state_d   = GAP;
                oe_d      = 1'b0;
                out_d     = 1'b1;
                fin_d     = 1'b1;
                gap_cnt_d = GAP_LAST;
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    accept  = send_en;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                oe_d    = 1'b0;
                out_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (accept) begin
            state_d   = SHIFT;
            sreg_d    = {2'b01, cmd_index, argument};
            crc_d     = '0;
            bit_cnt_d = '0;
            out_d     = 1'b0;
            oe_d      = 1'b1;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge sd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            crc_q     <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            out_q     <= 1'b1;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
        end
    end

    assign sd_cmd_out       = out_q;
    assign sd_cmd_oe        = oe_q;
    assign busy             = busy_q;
    assign sd_send_finished = fin_q;

endmodule
